// File: rtl/rc5_rx_fifo_pkg.sv
// Shared constants and types for the RC5 frame receiver: register offsets,
// STAT/CTRL bit positions, FSM state encoding and the CTRL reset value.
package rc5_rx_fifo_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    localparam int STAT_ERR     = 0;
    localparam int STAT_OVF     = 1;
    localparam int STAT_LVL_LSB = 8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_INV    = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_FLUSH  = 3;

    localparam logic [2:0] CTRL_RESET = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_BITS  = 3'd2,
        ST_PUSH  = 3'd3,
        ST_GUARD = 3'd4
    } rx_state_e;

    // Field order matches CTRL[2:0].
    typedef struct packed {
        logic irq_en;
        logic invert;
        logic enable;
    } ctrl_t;

endpackage

// File: rtl/rc5_rx_fifo_if.sv
// CSR bus between a bus master and the RC5 receiver; also carries the
// receiver FSM state out for observation.
interface rc5_rx_fifo_if;
    import rc5_rx_fifo_pkg::*;

    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    rx_state_e   fsm_state;

    modport master (output csr_a, csr_we, csr_di, input csr_do, fsm_state);
    modport slave  (input csr_a, csr_we, csr_di, output csr_do, fsm_state);

endinterface

// File: rtl/rc5_rx_fifo_fifo.sv
// Synchronous frame FIFO with a fall-through head word and a level count
// one bit wider than the pointers so full and empty are distinct.
module rc5_rx_fifo_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    // push_i/pop_i are single-cycle requests with no ready: a push while full
    // or a pop while empty is dropped; flush wins over both.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      lvl_q;
    logic             do_push, do_pop;

    assign full_o  = (lvl_q == (AW+1)'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign level_o = lvl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/rc5_rx_fifo.sv
// RC5/Manchester IR frame receiver: tick generator, line synchroniser,
// decode FSM, frame FIFO and CSR bank with a level interrupt.
module rc5_rx_fifo
    import rc5_rx_fifo_pkg::*;
#(
    parameter logic [3:0] csr_addr   = 4'h0,
    parameter int         clk_freq   = 100000000,
    parameter int         bit_rate   = 570,
    parameter int         frame_bits = 14,
    parameter int         fifo_depth = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    rc5_rx_fifo_if.slave csr,
    output logic         irq,
    input  logic         rx
);
    localparam int         DIV      = clk_freq / bit_rate / 16;
    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam int         LW       = $clog2(fifo_depth) + 1;
    localparam logic [4:0] LAST_BIT = 5'(frame_bits - 1);

    logic [15:0] div_q, div_d;
    logic        tick, sync1_q, sync2_q, line;
    rx_state_e   state_q, state_d;
    logic [3:0]  phase_q, phase_d, phase_nx;
    logic [4:0]  bit_q, bit_d;
    logic        half_q, half_d;
    logic [frame_bits-1:0] shift_q, shift_d, fifo_head;
    logic        fsm_push, err_set, ovf_set;
    logic        err_q, err_d, ovf_q, ovf_d, irq_q, irq_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] csr_do_q, csr_do_d, data_word;
    logic        fifo_full, fifo_empty, fifo_pop, fifo_flush;
    logic [LW-1:0] fifo_level;
    logic        sel, wr, rd;
    logic [1:0]  reg_a;

    assign tick     = (div_q == 16'd0);
    assign div_d    = tick ? DIV_M1 : div_q - 16'd1;
    assign line     = sync2_q ^ ctrl_q.invert;
    assign phase_nx = phase_q + 4'd1;

    // Phase counts ticks since the S1 mid-edge, so phase 12 is the first half
    // of the next bit and phase 4 the second half of the current one.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        half_d   = half_q;
        shift_d  = shift_q;
        fsm_push = 1'b0;
        err_set  = 1'b0;
        if (!ctrl_q.enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (tick && line) begin
                    state_d = ST_FIRST;
                    phase_d = 4'd0;
                    bit_d   = 5'd0;
                end
                ST_FIRST: if (tick) begin
                    phase_d = phase_nx;
                    if (phase_nx == 4'd4) begin
                        if (line) begin
                            bit_d   = 5'd1;
                            shift_d = {{(frame_bits-1){1'b0}}, 1'b1};
                            state_d = ST_BITS;
                        end else begin
                            err_set = 1'b1;
                            phase_d = 4'd0;
                            state_d = ST_GUARD;
                        end
                    end
                end
                ST_BITS: if (tick) begin
                    phase_d = phase_nx;
                    if (phase_nx == 4'd12) begin
                        half_d = line;
                    end else if (phase_nx == 4'd4) begin
                        if (line == half_q) begin
                            err_set = 1'b1;
                            phase_d = 4'd0;
                            state_d = ST_GUARD;
                        end else begin
                            shift_d = {shift_q[frame_bits-2:0], line};
                            if (bit_q == LAST_BIT) state_d = ST_PUSH;
                            else                   bit_d   = bit_q + 5'd1;
                        end
                    end
                end
                ST_PUSH: begin
                    fsm_push = 1'b1;
                    phase_d  = 4'd0;
                    state_d  = ST_GUARD;
                end
                ST_GUARD: if (tick) begin
                    if (line)                  phase_d = 4'd0;
                    else if (phase_q == 4'd15) state_d = ST_IDLE;
                    else                       phase_d = phase_nx;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    rc5_rx_fifo_fifo #(.WIDTH(frame_bits), .DEPTH(fifo_depth)) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .push_i  (fsm_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .din_i   (shift_q),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign sel        = (csr.csr_a[13:10] == csr_addr);
    assign reg_a      = csr.csr_a[1:0];
    assign wr         = sel && csr.csr_we;
    assign rd         = sel && !csr.csr_we;
    assign fifo_pop   = rd && (reg_a == REG_DATA) && !fifo_empty;
    assign fifo_flush = wr && (reg_a == REG_CTRL) && csr.csr_di[CTRL_FLUSH];
    assign ovf_set    = fsm_push && fifo_full;

    // A flag raised in the same cycle as its W1C clear stays set.
    assign err_d  = (err_q & ~(wr && reg_a == REG_STAT && csr.csr_di[STAT_ERR])) | err_set;
    assign ovf_d  = (ovf_q & ~(wr && reg_a == REG_STAT && csr.csr_di[STAT_OVF])) | ovf_set;
    assign ctrl_d = (wr && reg_a == REG_CTRL) ? ctrl_t'(csr.csr_di[2:0]) : ctrl_q;
    assign irq_d  = ctrl_q.irq_en && (fifo_level != '0);

    always_comb begin
        data_word = '0;
        if (!fifo_empty) begin
            data_word[frame_bits-1:0] = fifo_head;
            data_word[31]             = 1'b1;
        end
    end

    always_comb begin
        csr_do_d = '0;
        if (rd) begin
            case (reg_a)
                REG_DATA: csr_do_d = data_word;
                REG_STAT: begin
                    csr_do_d[STAT_ERR] = err_q;
                    csr_do_d[STAT_OVF] = ovf_q;
                    csr_do_d[STAT_LVL_LSB +: 8] = 8'(fifo_level);
                end
                REG_CTRL: csr_do_d[2:0] = ctrl_q;
                default:  csr_do_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q    <= DIV_M1;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            half_q   <= 1'b0;
            shift_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ctrl_q   <= ctrl_t'(CTRL_RESET);
            irq_q    <= 1'b0;
            csr_do_q <= '0;
        end else begin
            div_q    <= div_d;
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            half_q   <= half_d;
            shift_q  <= shift_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            ctrl_q   <= ctrl_d;
            irq_q    <= irq_d;
            csr_do_q <= csr_do_d;
        end
    end

    assign csr.csr_do    = csr_do_q;
    assign csr.fsm_state = state_q;
    assign irq           = irq_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, csr.csr_a[9:2], csr.csr_di[31:4]};

endmodule
